// File: rtl/sipo_framer_pkg.sv
// Shared types and helpers for the serial-in/parallel-out framer.
package sipo_framer_pkg;

  typedef enum logic {HUNT, LOCK} state_e;

  // Increment that sticks at max instead of wrapping.
  function automatic int unsigned sat_inc(input int unsigned v, input int unsigned max);
    return (v >= max) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/sipo_shift.sv
// Shift register with selectable direction and a fill counter that qualifies pattern hits.
module sipo_shift
  import sipo_framer_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             p_i,
  input  logic             clr_i,
  input  logic             fill_rst_i,
  output logic [WIDTH-1:0] sr_o,
  output logic [WIDTH-1:0] sr_next_o,
  output logic             fill_ok_o
);

  localparam int unsigned FillW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] sr_q, sr_d;
  logic [FillW-1:0] fill_q, fill_d;

  always_comb begin
    if (MSB_FIRST) begin
      sr_next_o = {sr_q[WIDTH-2:0], p_i};
    end else begin
      sr_next_o = {p_i, sr_q[WIDTH-1:1]};
    end
  end

  // The bit being sampled now counts toward the fill.
  assign fill_ok_o = (32'(fill_q) + 32'd1) >= WIDTH;
  assign sr_o      = sr_q;

  always_comb begin
    sr_d   = sr_q;
    fill_d = fill_q;
    if (clr_i) begin
      sr_d   = '0;
      fill_d = '0;
    end else if (en_i) begin
      sr_d   = sr_next_o;
      fill_d = fill_rst_i ? '0 : FillW'(sat_inc(32'(fill_q), WIDTH));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sr_q   <= '0;
      fill_q <= '0;
    end else begin
      sr_q   <= sr_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/sipo_framer.sv
// Serial-to-parallel framer: hunts for a sync pattern, then emits aligned WIDTH-bit words.
module sipo_framer
  import sipo_framer_pkg::*;
#(
  parameter int unsigned      WIDTH     = 4,
  parameter bit               MSB_FIRST = 1'b1,
  parameter logic [WIDTH-1:0] PATTERN   = 4'b1101,
  parameter bit               OVERLAP   = 1'b1,
  parameter int unsigned      CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             p,
  input  logic             sync_clr,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] word,
  output logic             word_valid,
  output logic             match,
  output logic             locked,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int unsigned BitW   = $clog2(WIDTH);
  localparam int unsigned CntMax = 32'((64'd1 << CNT_W) - 64'd1);

  state_e           state_q;
  logic [BitW-1:0]  bitcnt_q;
  logic [WIDTH-1:0] sr_next;
  logic             fill_ok;
  logic             hit;

  assign hit    = en & fill_ok & (sr_next == PATTERN);
  assign locked = (state_q == LOCK);

  sipo_shift #(
    .WIDTH    (WIDTH),
    .MSB_FIRST(MSB_FIRST)
  ) u_shift (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .en_i      (en),
    .p_i       (p),
    .clr_i     (sync_clr),
    .fill_rst_i(hit & ~OVERLAP),
    .sr_o      (Q),
    .sr_next_o (sr_next),
    .fill_ok_o (fill_ok)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= HUNT;
      bitcnt_q   <= '0;
      word       <= '0;
      word_valid <= 1'b0;
      match      <= 1'b0;
      match_cnt  <= '0;
    end else if (sync_clr) begin
      state_q    <= HUNT;
      bitcnt_q   <= '0;
      word       <= '0;
      word_valid <= 1'b0;
      match      <= 1'b0;
      match_cnt  <= '0;
    end else begin
      match      <= hit;
      word_valid <= 1'b0;
      if (hit) begin
        match_cnt <= CNT_W'(sat_inc(32'(match_cnt), CntMax));
      end
      if (en) begin
        unique case (state_q)
          HUNT: begin
            // Pattern bits themselves are never emitted as a word.
            if (hit) begin
              state_q  <= LOCK;
              bitcnt_q <= '0;
            end
          end
          LOCK: begin
            if (bitcnt_q == BitW'(WIDTH - 1)) begin
              word       <= sr_next;
              word_valid <= 1'b1;
              bitcnt_q   <= '0;
            end else begin
              bitcnt_q <= bitcnt_q + 1'b1;
            end
          end
          default: state_q <= HUNT;
        endcase
      end
    end
  end

endmodule
